// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard/forwarding unit: forward-select codes, FSM states
// and the select-priority helpers used by the execute-stage operand muxes.
package hazard_forward_unit_pkg;

   localparam int PKG_RW = 3;

   typedef enum logic [1:0] {
      FU_MUX = 2'b00,
      FU_WB  = 2'b01,
      FU_EM  = 2'b10,
      FU_MW  = 2'b11
   } fu_sel_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } fsm_state_e;

   // A load sitting in MEM has no result yet, so it never wins the EM path.
   function automatic fu_sel_e src_sel_f(
      input logic used,
      input logic mem_hit,
      input logic mem_ld,
      input logic wb_hit
   );
      fu_sel_e sel;
      sel = FU_MUX;
      if (used) begin
         if (mem_hit && !mem_ld) begin
            sel = FU_EM;
         end else if (wb_hit) begin
            sel = FU_WB;
         end
      end
      return sel;
   endfunction

   function automatic fu_sel_e dst_sel_f(
      input logic used,
      input logic mem_hit,
      input logic mem_ld,
      input logic wb_hit,
      input logic wb_ld
   );
      fu_sel_e sel;
      sel = FU_MUX;
      if (used) begin
         if (mem_hit && !mem_ld) begin
            sel = FU_EM;
         end else if (wb_hit && wb_ld) begin
            sel = FU_WB;
         end else if (wb_hit) begin
            sel = FU_MW;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_forward_unit_pipe_slot.sv
// One shadow pipeline slot: a synchronous-reset register that loads an all-zero
// (invalid) entry instead of its input whenever a bubble is requested.
module pipe_slot #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_bubble,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst || i_bubble) begin
         r_q <= '0;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Shadows EX/MEM/WB destination info, drives the execute-stage forward selects,
// and inserts a single stall plus bubble on a load-use dependency.
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
#(
   parameter int RW = PKG_RW,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [RW-1:0] id_src,
   input  logic [RW-1:0] id_dst,
   input  logic          id_src_used,
   input  logic          id_dst_used,
   input  logic          id_wr_en,
   input  logic [RW-1:0] id_wr_reg,
   input  logic          id_mem_rd,
   input  logic          flush,
   output logic [1:0]    FU_Src_Sel,
   output logic [1:0]    FU_Dst_Sel,
   output logic          stall,
   output logic          idex_bubble,
   output logic [CW-1:0] stall_count
);

   typedef struct packed {
      logic          valid;
      logic [RW-1:0] src;
      logic [RW-1:0] dst;
      logic          src_used;
      logic          dst_used;
      logic          wr_en;
      logic [RW-1:0] wr_reg;
      logic          mem_rd;
   } ex_slot_t;

   typedef struct packed {
      logic          valid;
      logic          wr_en;
      logic [RW-1:0] wr_reg;
      logic          mem_rd;
   } mw_slot_t;

   ex_slot_t   w_ex_d;
   ex_slot_t   w_ex_q;
   mw_slot_t   w_mem_d;
   mw_slot_t   w_mem_q;
   mw_slot_t   w_wb_q;

   fsm_state_e r_state;
   logic [CW-1:0] r_stall_count;

   logic       w_stall;
   logic       w_idex_bubble;
   logic       w_load_use;
   fu_sel_e    w_src_sel;
   fu_sel_e    w_dst_sel;

   logic [RW-1:0] w_op_reg [2];
   logic          w_op_used [2];
   logic [RW-1:0] w_id_reg [2];
   logic          w_id_used [2];
   logic [1:0]    w_mem_hit;
   logic [1:0]    w_wb_hit;
   logic [1:0]    w_lu_hit;

   always_comb begin
      w_ex_d          = '0;
      w_ex_d.valid    = id_valid;
      w_ex_d.src      = id_src;
      w_ex_d.dst      = id_dst;
      w_ex_d.src_used = id_src_used;
      w_ex_d.dst_used = id_dst_used;
      w_ex_d.wr_en    = id_wr_en;
      w_ex_d.wr_reg   = id_wr_reg;
      w_ex_d.mem_rd   = id_mem_rd;
   end

   always_comb begin
      w_mem_d        = '0;
      w_mem_d.valid  = w_ex_q.valid;
      w_mem_d.wr_en  = w_ex_q.wr_en;
      w_mem_d.wr_reg = w_ex_q.wr_reg;
      w_mem_d.mem_rd = w_ex_q.mem_rd;
   end

   pipe_slot #(.W($bits(ex_slot_t))) u_ex_slot (
      .clk      (clk),
      .rst      (rst),
      .i_bubble (w_idex_bubble),
      .i_d      (w_ex_d),
      .o_q      (w_ex_q)
   );

   pipe_slot #(.W($bits(mw_slot_t))) u_mem_slot (
      .clk      (clk),
      .rst      (rst),
      .i_bubble (1'b0),
      .i_d      (w_mem_d),
      .o_q      (w_mem_q)
   );

   pipe_slot #(.W($bits(mw_slot_t))) u_wb_slot (
      .clk      (clk),
      .rst      (rst),
      .i_bubble (1'b0),
      .i_d      (w_mem_q),
      .o_q      (w_wb_q)
   );

   // Index 0 is the first (Rsrc) operand, index 1 the second (Rdst) operand.
   assign w_op_reg[0]  = w_ex_q.src;
   assign w_op_reg[1]  = w_ex_q.dst;
   assign w_op_used[0] = w_ex_q.src_used;
   assign w_op_used[1] = w_ex_q.dst_used;
   assign w_id_reg[0]  = id_src;
   assign w_id_reg[1]  = id_dst;
   assign w_id_used[0] = id_src_used;
   assign w_id_used[1] = id_dst_used;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_op
         assign w_mem_hit[gi] = w_mem_q.valid & w_mem_q.wr_en &
                                (w_mem_q.wr_reg == w_op_reg[gi]);
         assign w_wb_hit[gi]  = w_wb_q.valid & w_wb_q.wr_en &
                                (w_wb_q.wr_reg == w_op_reg[gi]);
         assign w_lu_hit[gi]  = w_id_used[gi] & (w_id_reg[gi] == w_ex_q.wr_reg);
      end
   endgenerate

   assign w_src_sel = src_sel_f(w_op_used[0], w_mem_hit[0], w_mem_q.mem_rd, w_wb_hit[0]);
   assign w_dst_sel = dst_sel_f(w_op_used[1], w_mem_hit[1], w_mem_q.mem_rd, w_wb_hit[1],
                                w_wb_q.mem_rd);

   assign w_load_use = w_ex_q.valid & w_ex_q.mem_rd & w_ex_q.wr_en & id_valid &
                       (|w_lu_hit);

   // Flush squashes the consumer itself, so it overrides any load-use stall.
   assign w_stall       = (r_state == ST_IDLE) & w_load_use & ~flush;
   assign w_idex_bubble = w_stall | flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_stall_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_stall) begin
                  r_state <= ST_STALL;
               end
            end
            ST_STALL: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
         if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CW'(1);
         end
      end
   end

   assign FU_Src_Sel  = w_src_sel;
   assign FU_Dst_Sel  = w_dst_sel;
   assign stall       = w_stall;
   assign idex_bubble = w_idex_bubble;
   assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector scoreboard bench for hazard_forward_unit; a second instance with a
// 3-bit counter exercises stall_count saturation.
module tb_hazard_forward_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [2:0]  id_src;
   logic [2:0]  id_dst;
   logic        id_src_used;
   logic        id_dst_used;
   logic        id_wr_en;
   logic [2:0]  id_wr_reg;
   logic        id_mem_rd;
   logic        flush;
   logic [1:0]  fu_src_sel;
   logic [1:0]  fu_dst_sel;
   logic        stall;
   logic        idex_bubble;
   logic [15:0] stall_count;
   logic [1:0]  sat_src_sel;
   logic [1:0]  sat_dst_sel;
   logic        sat_stall;
   logic        sat_bubble;
   logic [2:0]  sat_count;

   typedef struct {
      string       nm;
      logic [1:0]  s;
      logic [1:0]  d;
      logic        st;
      logic        bb;
      logic [15:0] c;
      logic [2:0]  cs;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hazard_forward_unit #(.RW(3), .CW(16)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_src      (id_src),
      .id_dst      (id_dst),
      .id_src_used (id_src_used),
      .id_dst_used (id_dst_used),
      .id_wr_en    (id_wr_en),
      .id_wr_reg   (id_wr_reg),
      .id_mem_rd   (id_mem_rd),
      .flush       (flush),
      .FU_Src_Sel  (fu_src_sel),
      .FU_Dst_Sel  (fu_dst_sel),
      .stall       (stall),
      .idex_bubble (idex_bubble),
      .stall_count (stall_count)
   );

   hazard_forward_unit #(.RW(3), .CW(3)) u_dut_sat (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_src      (id_src),
      .id_dst      (id_dst),
      .id_src_used (id_src_used),
      .id_dst_used (id_dst_used),
      .id_wr_en    (id_wr_en),
      .id_wr_reg   (id_wr_reg),
      .id_mem_rd   (id_mem_rd),
      .flush       (flush),
      .FU_Src_Sel  (sat_src_sel),
      .FU_Dst_Sel  (sat_dst_sel),
      .stall       (sat_stall),
      .idex_bubble (sat_bubble),
      .stall_count (sat_count)
   );

   task automatic drive(input logic v, input logic [2:0] s, input logic [2:0] d,
                        input logic su, input logic du, input logic we,
                        input logic [2:0] wr, input logic mr, input logic fl,
                        input logic rs);
      id_valid    = v;
      id_src      = s;
      id_dst      = d;
      id_src_used = su;
      id_dst_used = du;
      id_wr_en    = we;
      id_wr_reg   = wr;
      id_mem_rd   = mr;
      flush       = fl;
      rst         = rs;
   endtask

   // One decode-stage cycle: apply inputs just after the edge and queue the
   // outputs expected while they are held.
   task automatic row(input string nm, input logic v, input logic [2:0] s,
                      input logic [2:0] d, input logic su, input logic du,
                      input logic we, input logic [2:0] wr, input logic mr,
                      input logic fl, input logic rs, input logic [1:0] es,
                      input logic [1:0] ed, input logic est, input logic eb,
                      input logic [15:0] ec, input logic [2:0] ecs);
      exp_t e;
      @(posedge clk);
      #1;
      drive(v, s, d, su, du, we, wr, mr, fl, rs);
      e.nm = nm; e.s = es; e.d = ed; e.st = est; e.bb = eb; e.c = ec; e.cs = ecs;
      sb_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (fu_src_sel !== e.s) begin
               errors++;
               $display("FAIL %s FU_Src_Sel got %b want %b", e.nm, fu_src_sel, e.s);
            end
            checks++;
            if (fu_dst_sel !== e.d) begin
               errors++;
               $display("FAIL %s FU_Dst_Sel got %b want %b", e.nm, fu_dst_sel, e.d);
            end
            checks++;
            if (stall !== e.st) begin
               errors++;
               $display("FAIL %s stall got %b want %b", e.nm, stall, e.st);
            end
            checks++;
            if (idex_bubble !== e.bb) begin
               errors++;
               $display("FAIL %s idex_bubble got %b want %b", e.nm, idex_bubble, e.bb);
            end
            checks++;
            if (stall_count !== e.c) begin
               errors++;
               $display("FAIL %s stall_count got %0d want %0d", e.nm, stall_count, e.c);
            end
            checks++;
            if (sat_count !== e.cs) begin
               errors++;
               $display("FAIL %s sat_stall_count got %0d want %0d", e.nm, sat_count, e.cs);
            end
            $display("check %-14s src=%b dst=%b stall=%b bubble=%b cnt=%0d sat=%0d",
                     e.nm, fu_src_sel, fu_dst_sel, stall, idex_bubble, stall_count,
                     sat_count);
         end
      end
   end

   initial begin : stimulus
      int wait_cycles;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (2) @(posedge clk);

      //   name          v  s  d su du we wr mr fl rs  es ed st bb cnt sat
      row("reset",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      row("alu_r1",      1, 6, 7, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      row("add_r2_r1",   1, 1, 2, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      row("chain_em",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
      row("alu_r3",      1, 5, 5, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      row("indep",       1, 6, 6, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      row("use_r3_dst",  1, 7, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      row("gap_mw",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
      row("drain1",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      row("ldd_r4",      1, 0, 0, 1, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      row("lu_stall",    1, 4, 5, 1, 1, 1, 5, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      row("lu_hold",     1, 4, 5, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      row("lu_fwd_wb",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
      row("drain2",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      row("alu_r1_a",    1, 2, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      row("alu_r1_b",    1, 2, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      row("use_r1",      1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      row("dbl_em",      1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 2, 2, 0, 0, 1, 1);
      row("imm_src",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 1);
      row("drain3",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      row("ldd_r4_b",    1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 1);
      row("flush_lu",    1, 4, 0, 1, 0, 1, 5, 0, 1, 0, 0, 0, 0, 1, 1, 1);
      row("post_flush",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      row("ldd_r2",      1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1);
      row("lu_dst",      1, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
      row("rst_in_stall",1, 0, 2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 2);
      row("after_rst",   1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      row("idle_stall",  1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      row("idle_hold",   1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

      // Eight back-to-back load-use pairs drive the 3-bit counter into saturation.
      for (int k = 0; k < 8; k++) begin
         row("sat_ldd",  1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1, 0, 0, 0,
             16'(1 + k), 3'((1 + k) > 7 ? 7 : (1 + k)));
         row("sat_stall",1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
             16'(1 + k), 3'((1 + k) > 7 ? 7 : (1 + k)));
         row("sat_hold", 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
             16'(2 + k), 3'((2 + k) > 7 ? 7 : (2 + k)));
      end
      row("sat_final",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 9, 7);

      wait_cycles = 0;
      while (sb_q.size() > 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (sb_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
